// File: rtl/ins_fetch_bp.sv
// -----------------------------------------------------------------------------
// ins_fetch_bp
// Fetch unit sitting between the instruction cache and the dispatcher.
// Drives the fetch PC, predicts conditional branches with a table of 2-bit
// saturating counters, decodes each fetched word and buffers the decoded
// instruction in a small fetch queue. A JALR stops fetching until the ROB
// redirects the PC with clear/new_pc.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   rdy                 global ready, 0 freezes all state
//   hit, ins            icache reply for addr_to_icache (valid this cycle)
//   addr_to_icache      current fetch PC
//   rob_full, lsb_full  back-pressure from ROB / load-store buffer
//   issue_en            one-cycle pulse, issue fields below are valid
//   once_pc, opcode,
//   rd, rs1, rs2, imm   fields of the issued instruction
//   is_br               issued instruction is a branch predicted taken
//   clear, new_pc       ROB redirect (flush queue, restart fetch at new_pc)
//   upt_en, pre_id,
//   is_jump             BHT training strobe, index and resolved outcome
//
// Decoded opcode numbering (6 bits):
//   0 unknown, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR,
//   5 BEQ, 6 BNE, 7 BLT, 8 BGE, 9 BLTU, 10 BGEU,
//   11 LB, 12 LH, 13 LW, 14 LBU, 15 LHU, 16 SB, 17 SH, 18 SW,
//   19 ADDI, 20 SLTI, 21 SLTIU, 22 XORI, 23 ORI, 24 ANDI, 25 SLLI, 26 SRLI,
//   27 SRAI, 28 ADD, 29 SUB, 30 SLL, 31 SLT, 32 SLTU, 33 XOR, 34 SRL,
//   35 SRA, 36 OR, 37 AND
// -----------------------------------------------------------------------------
module ins_fetch_bp #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          BHT_IDX_W = 5,
   parameter logic [1:0]  CTR_INIT  = 2'b10,
   parameter int          FQ_DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic                 hit,
   input  logic [31:0]          ins,
   output logic [31:0]          addr_to_icache,
   input  logic                 rob_full,
   input  logic                 lsb_full,
   output logic                 issue_en,
   output logic [31:0]          once_pc,
   output logic [5:0]           opcode,
   output logic [4:0]           rd,
   output logic [4:0]           rs1,
   output logic [4:0]           rs2,
   output logic [31:0]          imm,
   output logic                 is_br,
   input  logic                 clear,
   input  logic [31:0]          new_pc,
   input  logic                 upt_en,
   input  logic [BHT_IDX_W-1:0] pre_id,
   input  logic                 is_jump
);

   localparam int PTR_W  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int BHT_N  = 1 << BHT_IDX_W;
   localparam logic [CNT_W-1:0] FQ_FULL = CNT_W'(FQ_DEPTH);

   localparam logic [6:0] RV_LUI    = 7'b0110111;
   localparam logic [6:0] RV_AUIPC  = 7'b0010111;
   localparam logic [6:0] RV_JAL    = 7'b1101111;
   localparam logic [6:0] RV_JALR   = 7'b1100111;
   localparam logic [6:0] RV_BRANCH = 7'b1100011;
   localparam logic [6:0] RV_LOAD   = 7'b0000011;
   localparam logic [6:0] RV_STORE  = 7'b0100011;
   localparam logic [6:0] RV_OPIMM  = 7'b0010011;
   localparam logic [6:0] RV_OP     = 7'b0110011;

   typedef enum logic {ST_RUN, ST_WAIT_REDIR} state_t;

   // Saturating 2-bit counter step: taken counts up to 11, not-taken down to 00.
   function automatic logic [1:0] f_sat_ctr(input logic [1:0] ctr, input logic taken);
      if (taken) f_sat_ctr = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      else       f_sat_ctr = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
   endfunction

   // Control state
   logic [31:0]      r_pc;
   state_t           r_state;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [1:0]       r_bht [0:BHT_N-1];

   // Fetch-queue storage (data only, no reset needed)
   logic [31:0]        r_fq_pc  [0:FQ_DEPTH-1];
   logic [5:0]         r_fq_op  [0:FQ_DEPTH-1];
   logic [4:0]         r_fq_rd  [0:FQ_DEPTH-1];
   logic [4:0]         r_fq_rs1 [0:FQ_DEPTH-1];
   logic [4:0]         r_fq_rs2 [0:FQ_DEPTH-1];
   logic signed [31:0] r_fq_imm [0:FQ_DEPTH-1];
   logic               r_fq_br  [0:FQ_DEPTH-1];

   // Issue stage registers
   logic               r_vld_p1;
   logic [31:0]        r_pc_p1;
   logic [5:0]         r_op_p1;
   logic [4:0]         r_rd_p1;
   logic [4:0]         r_rs1_p1;
   logic [4:0]         r_rs2_p1;
   logic signed [31:0] r_imm_p1;
   logic               r_br_p1;

   // Decode of the word returned by the icache
   logic [5:0]         w_op_p0;
   logic [4:0]         w_rd_p0;
   logic [4:0]         w_rs1_p0;
   logic [4:0]         w_rs2_p0;
   logic signed [31:0] w_imm_p0;

   logic [2:0] w_f3;
   logic       w_f7b;
   assign w_f3  = ins[14:12];
   assign w_f7b = ins[30];

   always_comb begin
      w_op_p0  = 6'd0;
      w_rd_p0  = 5'd0;
      w_rs1_p0 = 5'd0;
      w_rs2_p0 = 5'd0;
      w_imm_p0 = '0;
      case (ins[6:0])
         RV_LUI: begin
            w_op_p0  = 6'd1;
            w_rd_p0  = ins[11:7];
            w_imm_p0 = {ins[31:12], 12'b0};
         end
         RV_AUIPC: begin
            w_op_p0  = 6'd2;
            w_rd_p0  = ins[11:7];
            w_imm_p0 = {ins[31:12], 12'b0};
         end
         RV_JAL: begin
            w_op_p0  = 6'd3;
            w_rd_p0  = ins[11:7];
            w_imm_p0 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         end
         RV_JALR: begin
            w_op_p0  = 6'd4;
            w_rd_p0  = ins[11:7];
            w_rs1_p0 = ins[19:15];
            w_imm_p0 = {{20{ins[31]}}, ins[31:20]};
         end
         RV_BRANCH: begin
            w_rs1_p0 = ins[19:15];
            w_rs2_p0 = ins[24:20];
            w_imm_p0 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            case (w_f3)
               3'b000:  w_op_p0 = 6'd5;
               3'b001:  w_op_p0 = 6'd6;
               3'b100:  w_op_p0 = 6'd7;
               3'b101:  w_op_p0 = 6'd8;
               3'b110:  w_op_p0 = 6'd9;
               3'b111:  w_op_p0 = 6'd10;
               default: w_op_p0 = 6'd0;
            endcase
         end
         RV_LOAD: begin
            w_rd_p0  = ins[11:7];
            w_rs1_p0 = ins[19:15];
            w_imm_p0 = {{20{ins[31]}}, ins[31:20]};
            case (w_f3)
               3'b000:  w_op_p0 = 6'd11;
               3'b001:  w_op_p0 = 6'd12;
               3'b010:  w_op_p0 = 6'd13;
               3'b100:  w_op_p0 = 6'd14;
               3'b101:  w_op_p0 = 6'd15;
               default: w_op_p0 = 6'd0;
            endcase
         end
         RV_STORE: begin
            w_rs1_p0 = ins[19:15];
            w_rs2_p0 = ins[24:20];
            w_imm_p0 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            case (w_f3)
               3'b000:  w_op_p0 = 6'd16;
               3'b001:  w_op_p0 = 6'd17;
               3'b010:  w_op_p0 = 6'd18;
               default: w_op_p0 = 6'd0;
            endcase
         end
         RV_OPIMM: begin
            w_rd_p0  = ins[11:7];
            w_rs1_p0 = ins[19:15];
            w_imm_p0 = {{20{ins[31]}}, ins[31:20]};
            case (w_f3)
               3'b000:  w_op_p0 = 6'd19;
               3'b010:  w_op_p0 = 6'd20;
               3'b011:  w_op_p0 = 6'd21;
               3'b100:  w_op_p0 = 6'd22;
               3'b110:  w_op_p0 = 6'd23;
               3'b111:  w_op_p0 = 6'd24;
               3'b001: begin
                  w_op_p0  = 6'd25;
                  w_imm_p0 = {27'b0, ins[24:20]};
               end
               default: begin
                  // funct3 101: shift right, ins[30] picks arithmetic
                  w_op_p0  = w_f7b ? 6'd27 : 6'd26;
                  w_imm_p0 = {27'b0, ins[24:20]};
               end
            endcase
         end
         RV_OP: begin
            w_rd_p0  = ins[11:7];
            w_rs1_p0 = ins[19:15];
            w_rs2_p0 = ins[24:20];
            case (w_f3)
               3'b000:  w_op_p0 = w_f7b ? 6'd29 : 6'd28;
               3'b001:  w_op_p0 = 6'd30;
               3'b010:  w_op_p0 = 6'd31;
               3'b011:  w_op_p0 = 6'd32;
               3'b100:  w_op_p0 = 6'd33;
               3'b101:  w_op_p0 = w_f7b ? 6'd35 : 6'd34;
               3'b110:  w_op_p0 = 6'd36;
               default: w_op_p0 = 6'd37;
            endcase
         end
         default: begin
            w_op_p0 = 6'd0;
         end
      endcase
   end

   // Next-PC selection and branch prediction
   logic [BHT_IDX_W-1:0] w_bht_idx;
   logic                 w_bht_taken;
   logic [31:0]          w_pc_plus_imm;
   logic [31:0]          w_next_pc;
   logic                 w_pred_p0;
   logic                 w_is_jalr;

   assign w_bht_idx     = r_pc[BHT_IDX_W+1:2];
   assign w_bht_taken   = r_bht[w_bht_idx][1];
   assign w_pc_plus_imm = r_pc + $unsigned(w_imm_p0);

   always_comb begin
      w_next_pc = r_pc + 32'd4;
      w_pred_p0 = 1'b0;
      w_is_jalr = 1'b0;
      case (ins[6:0])
         RV_JAL: w_next_pc = w_pc_plus_imm;
         RV_BRANCH: begin
            w_pred_p0 = w_bht_taken;
            w_next_pc = w_bht_taken ? w_pc_plus_imm : r_pc + 32'd4;
         end
         RV_JALR: begin
            // Target unknown until the ROB resolves it; park the PC.
            w_next_pc = r_pc;
            w_is_jalr = 1'b1;
         end
         default: w_next_pc = r_pc + 32'd4;
      endcase
   end

   // Queue handshakes; a full queue never accepts, even with a same-cycle pop
   logic w_enq;
   logic w_deq;
   assign w_enq = rdy && !clear && hit && (r_state == ST_RUN) && (r_count < FQ_FULL);
   assign w_deq = rdy && !clear && (r_count != '0) && !rob_full && !lsb_full;

   // ---- stage p0: fetch/decode into the queue ----
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_fq_pc[r_wr_ptr]  <= r_pc;
         r_fq_op[r_wr_ptr]  <= w_op_p0;
         r_fq_rd[r_wr_ptr]  <= w_rd_p0;
         r_fq_rs1[r_wr_ptr] <= w_rs1_p0;
         r_fq_rs2[r_wr_ptr] <= w_rs2_p0;
         r_fq_imm[r_wr_ptr] <= w_imm_p0;
         r_fq_br[r_wr_ptr]  <= w_pred_p0;
      end
   end

   // ---- stage p1: queue head to issue outputs; PC, FSM, pointers, BHT ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc     <= RESET_PC;
         r_state  <= ST_RUN;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < BHT_N; i++) r_bht[i] <= CTR_INIT;
         r_vld_p1 <= 1'b0;
         r_pc_p1  <= '0;
         r_op_p1  <= '0;
         r_rd_p1  <= '0;
         r_rs1_p1 <= '0;
         r_rs2_p1 <= '0;
         r_imm_p1 <= '0;
         r_br_p1  <= 1'b0;
      end else if (!rdy) begin
         r_vld_p1 <= 1'b0;
      end else begin
         // Training is independent of redirects; a same-cycle lookup
         // above already used the old counter value.
         if (upt_en) r_bht[pre_id] <= f_sat_ctr(r_bht[pre_id], is_jump);

         if (clear) begin
            r_pc     <= new_pc;
            r_state  <= ST_RUN;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld_p1 <= 1'b0;
         end else begin
            if (w_enq) begin
               r_pc     <= w_next_pc;
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
               if (w_is_jalr) r_state <= ST_WAIT_REDIR;
            end
            if (w_deq) begin
               r_vld_p1 <= 1'b1;
               r_pc_p1  <= r_fq_pc[r_rd_ptr];
               r_op_p1  <= r_fq_op[r_rd_ptr];
               r_rd_p1  <= r_fq_rd[r_rd_ptr];
               r_rs1_p1 <= r_fq_rs1[r_rd_ptr];
               r_rs2_p1 <= r_fq_rs2[r_rd_ptr];
               r_imm_p1 <= r_fq_imm[r_rd_ptr];
               r_br_p1  <= r_fq_br[r_rd_ptr];
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
               r_vld_p1 <= 1'b0;
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
         end
      end
   end

   assign addr_to_icache = r_pc;
   assign issue_en       = r_vld_p1;
   assign once_pc        = r_pc_p1;
   assign opcode         = r_op_p1;
   assign rd             = r_rd_p1;
   assign rs1            = r_rs1_p1;
   assign rs2            = r_rs2_p1;
   assign imm            = $unsigned(r_imm_p1);
   assign is_br          = r_br_p1;

endmodule

// File: tb/tb_ins_fetch_bp.sv
// -----------------------------------------------------------------------------
// tb_ins_fetch_bp
// Directed bench for ins_fetch_bp. A small instruction memory answers every
// fetch (hit controls validity). Default memory word i is
// ADDI x(i%32), x0, i so issued rd/imm identify the fetch address.
// -----------------------------------------------------------------------------
module tb_ins_fetch_bp;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        hit;
   logic [31:0] ins;
   logic [31:0] addr_to_icache;
   logic        rob_full;
   logic        lsb_full;
   logic        issue_en;
   logic [31:0] once_pc;
   logic [5:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic        is_br;
   logic        clear;
   logic [31:0] new_pc;
   logic        upt_en;
   logic [4:0]  pre_id;
   logic        is_jump;

   int checks = 0;
   int errors = 0;

   logic [31:0] imem [0:127];

   localparam logic [31:0] BEQ_X1_X2_P32 = 32'h0220_8063; // beq x1,x2,+0x20
   localparam logic [31:0] JALR_X0_X1    = 32'h0000_8067; // jalr x0,0(x1)

   ins_fetch_bp #(
      .RESET_PC (32'h0),
      .BHT_IDX_W(5),
      .CTR_INIT (2'b10),
      .FQ_DEPTH (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .hit           (hit),
      .ins           (ins),
      .addr_to_icache(addr_to_icache),
      .rob_full      (rob_full),
      .lsb_full      (lsb_full),
      .issue_en      (issue_en),
      .once_pc       (once_pc),
      .opcode        (opcode),
      .rd            (rd),
      .rs1           (rs1),
      .rs2           (rs2),
      .imm           (imm),
      .is_br         (is_br),
      .clear         (clear),
      .new_pc        (new_pc),
      .upt_en        (upt_en),
      .pre_id        (pre_id),
      .is_jump       (is_jump)
   );

   always #5 clk = ~clk;

   assign ins = imem[addr_to_icache[8:2]];

   function automatic logic [31:0] mk_addi(input int i);
      logic [11:0] im;
      logic [4:0]  r;
      im = 12'(i);
      r  = 5'(i);
      return {im, 5'd0, 3'b000, r, 7'b0010011};
   endfunction

   task automatic load_mem();
      for (int i = 0; i < 128; i++) imem[i] = mk_addi(i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      rdy      = 1'b1;
      hit      = 1'b0;
      rob_full = 1'b0;
      lsb_full = 1'b0;
      clear    = 1'b0;
      new_pc   = 32'h0;
      upt_en   = 1'b0;
      pre_id   = 5'd0;
      is_jump  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      load_mem();

      // ---------------- 1: straight-line ADDI stream ----------------
      do_reset();
      chk("rst_issue_en", 32'(issue_en), 32'd0);
      chk("rst_once_pc", once_pc, 32'h0);
      chk("rst_addr", addr_to_icache, 32'h0);
      chk("rst_imm", imm, 32'h0);
      chk("rst_is_br", 32'(is_br), 32'd0);
      hit = 1'b1;
      step();
      chk("t1_e1_addr", addr_to_icache, 32'h4);
      chk("t1_e1_issue", 32'(issue_en), 32'd0);
      step();
      chk("t1_e2_issue", 32'(issue_en), 32'd1);
      chk("t1_e2_pc", once_pc, 32'h0);
      step();
      chk("t1_e3_pc", once_pc, 32'h4);
      chk("t1_e3_rd", 32'(rd), 32'd1);
      chk("t1_e3_imm", imm, 32'd1);
      chk("t1_e3_opcode", 32'(opcode), 32'd19);
      step();
      chk("t1_e4_issue", 32'(issue_en), 32'd1);
      chk("t1_e4_pc", once_pc, 32'h8);
      chk("t1_e4_rd", 32'(rd), 32'd2);
      rdy = 1'b0;
      step();
      chk("t1_frz_issue", 32'(issue_en), 32'd0);
      chk("t1_frz_addr", addr_to_icache, 32'h10);
      rdy = 1'b1;
      hit = 1'b0;
      step();
      chk("t1_thaw_issue", 32'(issue_en), 32'd1);
      chk("t1_thaw_pc", once_pc, 32'hC);

      // ---------------- 2: BEQ prediction and training ----------------
      do_reset();
      imem[4] = BEQ_X1_X2_P32;
      hit = 1'b1;
      repeat (4) step();
      chk("t2_addr_10", addr_to_icache, 32'h10);
      step();
      chk("t2_addr_taken", addr_to_icache, 32'h30);
      chk("t2_addi_pc", once_pc, 32'hC);
      chk("t2_addi_isbr", 32'(is_br), 32'd0);
      hit = 1'b0;
      step();
      chk("t2_beq_issue", 32'(issue_en), 32'd1);
      chk("t2_beq_pc", once_pc, 32'h10);
      chk("t2_beq_isbr", 32'(is_br), 32'd1);
      chk("t2_beq_rs1", 32'(rs1), 32'd1);
      chk("t2_beq_rs2", 32'(rs2), 32'd2);
      chk("t2_beq_imm", imm, 32'h20);
      chk("t2_beq_opcode", 32'(opcode), 32'd5);
      step();
      chk("t2_idle_issue", 32'(issue_en), 32'd0);
      upt_en  = 1'b1;
      pre_id  = 5'd4;
      is_jump = 1'b0;
      step();
      step();
      upt_en = 1'b0;
      clear  = 1'b1;
      new_pc = 32'h10;
      step();
      chk("t2_redir_addr", addr_to_icache, 32'h10);
      chk("t2_redir_issue", 32'(issue_en), 32'd0);
      clear = 1'b0;
      hit   = 1'b1;
      step();
      chk("t2_addr_nt", addr_to_icache, 32'h14);
      hit = 1'b0;
      step();
      chk("t2_nt_issue", 32'(issue_en), 32'd1);
      chk("t2_nt_pc", once_pc, 32'h10);
      chk("t2_nt_isbr", 32'(is_br), 32'd0);

      // ---------------- 3: back-pressure fills the queue ----------------
      load_mem();
      do_reset();
      rob_full = 1'b1;
      hit      = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t3_full_issue", 32'(issue_en), 32'd0);
      end
      chk("t3_stall_addr", addr_to_icache, 32'h10);
      rob_full = 1'b0;
      lsb_full = 1'b1;
      step();
      chk("t3_lsb_issue", 32'(issue_en), 32'd0);
      chk("t3_lsb_addr", addr_to_icache, 32'h10);
      lsb_full = 1'b0;
      step();
      chk("t3_i1_issue", 32'(issue_en), 32'd1);
      chk("t3_i1_pc", once_pc, 32'h0);
      chk("t3_nobypass_addr", addr_to_icache, 32'h10);
      step();
      chk("t3_i2_pc", once_pc, 32'h4);
      chk("t3_resume_addr", addr_to_icache, 32'h14);
      step();
      chk("t3_i3_pc", once_pc, 32'h8);
      step();
      chk("t3_i4_pc", once_pc, 32'hC);
      step();
      chk("t3_i5_pc", once_pc, 32'h10);
      chk("t3_i5_issue", 32'(issue_en), 32'd1);
      hit = 1'b0;

      // ---------------- 4: clear flushes a non-empty queue ----------------
      do_reset();
      rob_full = 1'b1;
      hit      = 1'b1;
      repeat (3) step();
      chk("t4_fill_addr", addr_to_icache, 32'hC);
      rob_full = 1'b0;
      clear    = 1'b1;
      new_pc   = 32'h100;
      step();
      chk("t4_clr_issue", 32'(issue_en), 32'd0);
      chk("t4_clr_addr", addr_to_icache, 32'h100);
      clear = 1'b0;
      step();
      chk("t4_flushed_issue", 32'(issue_en), 32'd0);
      chk("t4_fetch_addr", addr_to_icache, 32'h104);
      hit = 1'b0;
      step();
      chk("t4_new_issue", 32'(issue_en), 32'd1);
      chk("t4_new_pc", once_pc, 32'h100);
      chk("t4_new_imm", imm, 32'd64);
      step();
      chk("t4_empty_issue", 32'(issue_en), 32'd0);

      // ---------------- 5: JALR halts fetch until redirect ----------------
      do_reset();
      imem[2] = JALR_X0_X1;
      hit = 1'b1;
      step();
      step();
      step();
      chk("t5_jalr_addr", addr_to_icache, 32'h8);
      step();
      chk("t5_jalr_issue", 32'(issue_en), 32'd1);
      chk("t5_jalr_pc", once_pc, 32'h8);
      chk("t5_jalr_opcode", 32'(opcode), 32'd4);
      chk("t5_jalr_rs1", 32'(rs1), 32'd1);
      chk("t5_jalr_isbr", 32'(is_br), 32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t5_wait_issue", 32'(issue_en), 32'd0);
         chk("t5_wait_addr", addr_to_icache, 32'h8);
      end
      clear  = 1'b1;
      new_pc = 32'h40;
      step();
      chk("t5_redir_addr", addr_to_icache, 32'h40);
      clear = 1'b0;
      step();
      chk("t5_resume_addr", addr_to_icache, 32'h44);
      hit = 1'b0;
      step();
      chk("t5_resume_issue", 32'(issue_en), 32'd1);
      chk("t5_resume_pc", once_pc, 32'h40);

      // ---------------- 6: async reset mid-stream ----------------
      load_mem();
      imem[4] = BEQ_X1_X2_P32;
      do_reset();
      upt_en  = 1'b1;
      pre_id  = 5'd4;
      is_jump = 1'b0;
      step();
      step();
      upt_en = 1'b0;
      hit    = 1'b1;
      repeat (3) step();
      chk("t6_pre_issue", 32'(issue_en), 32'd1);
      chk("t6_pre_pc", once_pc, 32'h4);
      rst = 1'b0;
      #1;
      chk("t6_rst_issue", 32'(issue_en), 32'd0);
      chk("t6_rst_pc", once_pc, 32'h0);
      chk("t6_rst_rd", 32'(rd), 32'd0);
      chk("t6_rst_imm", imm, 32'h0);
      chk("t6_rst_addr", addr_to_icache, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      step();
      chk("t6_post_issue", 32'(issue_en), 32'd0);
      repeat (3) step();
      chk("t6_post_addr10", addr_to_icache, 32'h10);
      step();
      chk("t6_bht_reinit", addr_to_icache, 32'h30);
      hit = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
